uart_tx_fifo: RTL and testbench

Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter. The bus/core side writes bytes at any rate. The block buffers them and presents them one at a time on the transmitter's i_TX_DV/i_TX_Byte handshake. It issues a byte only when the transmitter is idle, and waits for its completion pulse before issuing the next.

---
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO and launch sequencer feeding a UART transmitter's
//            DV/byte handshake. Optional macro UART_TX_FIFO_DROP_CNT_EN adds
//            a saturating dropped-write counter (o_Drop_Count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Wr_En,
   input  logic [7:0]        i_Wr_Data,
   output logic              o_Full,
   output logic              o_Empty,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Overflow,
`ifdef UART_TX_FIFO_DROP_CNT_EN
   output logic [7:0]        o_Drop_Count,
`endif
   input  logic              i_Clr_Ovf,
   output logic              o_TX_DV,
   output logic [7:0]        o_TX_Byte,
   input  logic              i_TX_Active,
   input  logic              i_TX_Done,
   output logic              o_Busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_ACT  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W+1)'(1);

   state_t              state, state_nxt;
   logic [7:0]          mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     count;
   logic                wr_accept, pop, dv_nxt;

   assign o_Count   = count;
   assign o_Full    = (count == FULL_COUNT);
   assign o_Empty   = (count == '0);
   assign o_Busy    = (state != IDLE) || !o_Empty;
   assign wr_accept = i_Wr_En && !o_Full;

   // Storage carries no reset; only pointers and occupancy define content.
   always_ff @(posedge i_Clock) begin
      if (wr_accept) mem[wr_ptr] <= i_Wr_Data;
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)       rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_accept, pop})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n)                 o_Overflow <= 1'b0;
      else if (i_Clr_Ovf)           o_Overflow <= 1'b0;
      else if (i_Wr_En && o_Full)   o_Overflow <= 1'b1;
   end

`ifdef UART_TX_FIFO_DROP_CNT_EN
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n)
         o_Drop_Count <= 8'h00;
      else if (i_Clr_Ovf)
         o_Drop_Count <= 8'h00;
      else if (i_Wr_En && o_Full && (o_Drop_Count != 8'hFF))
         o_Drop_Count <= o_Drop_Count + 8'h01;
   end
`endif

   // Done high in IDLE means the transmitter is in cleanup and would ignore DV.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      dv_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!o_Empty && !i_TX_Active && !i_TX_Done) begin
               state_nxt = LAUNCH;
               pop       = 1'b1;
               dv_nxt    = 1'b1;
            end
         end
         LAUNCH:    state_nxt = WAIT_ACT;
         WAIT_ACT:  if (i_TX_Active) state_nxt = WAIT_DONE;
         WAIT_DONE: if (i_TX_Done)   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= IDLE;
         o_TX_DV   <= 1'b0;
         o_TX_Byte <= 8'h00;
      end else begin
         state   <= state_nxt;
         o_TX_DV <= dv_nxt;
         if (pop) o_TX_Byte <= mem[rd_ptr];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo with a behavioural
//            transmitter model; honours UART_TX_FIFO_DROP_CNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

   localparam int DEPTH      = 16;
   localparam int FRAME_CLKS = 40;   // 10 bits at 4 clocks per bit

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       clr_ovf = 1'b0;
   logic       full, empty, overflow, tx_dv, busy;
   logic [4:0] count;
   logic [7:0] tx_byte;
   logic       tx_active, tx_done;
`ifdef UART_TX_FIFO_DROP_CNT_EN
   logic [7:0] drop_count;
`endif

   // Transmitter model controls: auto mode runs frames, manual mode is scripted
   logic       auto_tx = 1'b0;
   logic       man_act = 1'b0;
   logic       man_done = 1'b0;
   int         done_len = 1;
   logic       m_act = 1'b0;
   logic       m_done = 1'b0;
   int         m_cnt = 0;
   int         m_dcnt = 0;
   logic [7:0] sent_q [$];

   int         checks = 0;
   int         errors = 0;
   int         dv_pulses = 0;
   logic       prev_dv = 1'b0;

   assign tx_active = auto_tx ? m_act  : man_act;
   assign tx_done   = auto_tx ? m_done : man_done;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Wr_En     (wr_en),
      .i_Wr_Data   (wr_data),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (count),
      .o_Overflow  (overflow),
`ifdef UART_TX_FIFO_DROP_CNT_EN
      .o_Drop_Count(drop_count),
`endif
      .i_Clr_Ovf   (clr_ovf),
      .o_TX_DV     (tx_dv),
      .o_TX_Byte   (tx_byte),
      .i_TX_Active (tx_active),
      .i_TX_Done   (tx_done),
      .o_Busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int limit);
      for (int n = 0; n < limit && busy; n++) step();
      chk("wait_idle", {31'd0, busy}, 32'd0);
   endtask

   always @(posedge clk) begin
      if (auto_tx && tx_dv && !m_act && !m_done) begin
         m_act <= 1'b1;
         m_cnt <= FRAME_CLKS - 1;
         sent_q.push_back(tx_byte);
      end else if (m_act) begin
         if (m_cnt == 0) begin
            m_act  <= 1'b0;
            m_done <= 1'b1;
            m_dcnt <= done_len - 1;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (m_done) begin
         if (m_dcnt == 0) m_done <= 1'b0;
         else             m_dcnt <= m_dcnt - 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && tx_dv) begin
         dv_pulses <= dv_pulses + 1;
         chk("dv_while_tx_busy", {30'd0, tx_active, tx_done}, 32'd0);
         chk("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
      end
      prev_dv <= tx_dv;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;

      // Reset state
      step(); step();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_dv", 32'(tx_dv), 0);
      chk("rst_byte", 32'(tx_byte), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      step();

      // 1: single byte, two-cycle launch latency
      auto_tx = 1'b1; done_len = 1;
      wr_en = 1'b1; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      chk("t1_count1", 32'(count), 1);
      chk("t1_dv_early", 32'(tx_dv), 0);
      chk("t1_busy", 32'(busy), 1);
      step();
      chk("t1_dv", 32'(tx_dv), 1);
      chk("t1_byte", 32'(tx_byte), 32'hA5);
      chk("t1_count0", 32'(count), 0);
      step();
      chk("t1_dv_low", 32'(tx_dv), 0);
      chk("t1_byte_hold", 32'(tx_byte), 32'hA5);
      wait_idle(200);
      chk("t1_sent_n", sent_q.size(), 1);
      if (sent_q.size() == 1) chk("t1_sent", 32'(sent_q[0]), 32'hA5);
      step(); step();

      // 2: burst of five, transmitter holds done for two cycles
      sent_q.delete(); done_len = 2; base = dv_pulses;
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      wait_idle(1000);
      chk("t2_pulses", 32'(dv_pulses - base), 5);
      chk("t2_sent_n", sent_q.size(), 5);
      for (int i = 0; i < 5 && i < sent_q.size(); i++)
         chk("t2_order", 32'(sent_q[i]), 32'(i + 1));
      step(); step();

      // 3: overflow with stalled transmitter
      auto_tx = 1'b0; man_act = 1'b1; base = dv_pulses;
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h10 + i);
         step();
      end
      wr_en = 1'b0;
      chk("t3_count", 32'(count), 16);
      chk("t3_full", 32'(full), 1);
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_no_dv", 32'(dv_pulses - base), 0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
      chk("t3_drops", 32'(drop_count), 4);
`endif
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_clr", 32'(overflow), 0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
      chk("t3_clr_drops", 32'(drop_count), 0);
`endif
      wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
      step();
      wr_en = 1'b0; clr_ovf = 1'b0;
      chk("t3_clr_wins", 32'(overflow), 0);
      chk("t3_count_kept", 32'(count), 16);
`ifdef UART_TX_FIFO_DROP_CNT_EN
      chk("t3_clr_wins_drops", 32'(drop_count), 0);
`endif
      sent_q.delete(); man_act = 1'b0; auto_tx = 1'b1;
      wait_idle(2500);
      chk("t3_sent_n", sent_q.size(), 16);
      for (int i = 0; i < 16 && i < sent_q.size(); i++)
         chk("t3_order", 32'(sent_q[i]), 32'(8'h10 + i));
      step(); step();

      // 4: three rounds of twelve to wrap the pointers
      for (int r = 0; r < 3; r++) begin
         sent_q.delete();
         for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + r * 16 + i);
            step();
         end
         wr_en = 1'b0;
         wait_idle(2000);
         chk("t4_sent_n", sent_q.size(), 12);
         for (int i = 0; i < 12 && i < sent_q.size(); i++)
            chk("t4_order", 32'(sent_q[i]), 32'(8'h40 + r * 16 + i));
         step(); step();
      end
      chk("t4_empty", 32'(empty), 1);

      // 5: done held two cycles must suppress launch
      auto_tx = 1'b0; man_act = 1'b1; man_done = 1'b0;
      wr_en = 1'b1; wr_data = 8'hB1; step();
      wr_data = 8'hB2; step();
      wr_en = 1'b0;
      man_act = 1'b0; man_done = 1'b1;
      step();
      chk("t5_dv_done1", 32'(tx_dv), 0);
      step();
      chk("t5_dv_done2", 32'(tx_dv), 0);
      man_done = 1'b0;
      step();
      chk("t5_dv1", 32'(tx_dv), 1);
      chk("t5_byte1", 32'(tx_byte), 32'hB1);
      step();
      man_act = 1'b1;
      step();
      man_act = 1'b0; man_done = 1'b1;
      step();
      chk("t5_dv_wd1", 32'(tx_dv), 0);
      step();
      chk("t5_dv_wd2", 32'(tx_dv), 0);
      man_done = 1'b0;
      step();
      chk("t5_dv2", 32'(tx_dv), 1);
      chk("t5_byte2", 32'(tx_byte), 32'hB2);
      step();
      man_act = 1'b1;
      step();
      man_act = 1'b0; man_done = 1'b1;
      step();
      man_done = 1'b0;
      step();
      chk("t5_idle", 32'(busy), 0);

      // 6: reset mid-frame with six bytes queued
      man_act = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h60 + i);
         step();
      end
      wr_en = 1'b0;
      chk("t6_queued", 32'(count), 6);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 32'(count), 0);
      chk("t6_rst_dv", 32'(tx_dv), 0);
      chk("t6_rst_empty", 32'(empty), 1);
      step();
      rst_n = 1'b1;
      wr_en = 1'b1; wr_data = 8'h3C;
      step();
      wr_en = 1'b0;
      chk("t6_count", 32'(count), 1);
      step();
      chk("t6_hold_act", 32'(tx_dv), 0);
      man_act = 1'b0; man_done = 1'b1;
      step();
      chk("t6_hold_done", 32'(tx_dv), 0);
      man_done = 1'b0;
      step();
      chk("t6_dv", 32'(tx_dv), 1);
      chk("t6_byte", 32'(tx_byte), 32'h3C);
      step();
      man_act = 1'b1;
      step();
      man_act = 1'b0; man_done = 1'b1;
      step();
      man_done = 1'b0;
      step();
      chk("t6_idle", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
